// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the fetch/load-store memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and lane select/extension for loads
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic        req_we_i,
    input  logic [2:0]  req_func3_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wdata_o,
    output logic        req_misaligned_o,
    input  logic [2:0]  ld_func3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    // 0 = byte, 1 = half, 2 = word
    logic [1:0]  req_size;
    logic [31:0] ld_shifted;

    always_comb begin
        req_size = 2'd2;
        if (req_we_i) begin
            case (req_func3_i)
                F3_B:    req_size = 2'd0;
                F3_H:    req_size = 2'd1;
                default: req_size = 2'd2;
            endcase
        end else begin
            case (req_func3_i)
                F3_B, F3_BU: req_size = 2'd0;
                F3_H, F3_HU: req_size = 2'd1;
                default:     req_size = 2'd2;
            endcase
        end
    end

    always_comb begin
        req_misaligned_o = 1'b0;
        req_be_o         = 4'b1111;
        req_wdata_o      = 32'd0;
        case (req_size)
            2'd0: req_misaligned_o = 1'b0;
            2'd1: req_misaligned_o = req_addr_lo_i[0];
            default: req_misaligned_o = |req_addr_lo_i;
        endcase
        if (req_we_i) begin
            case (req_size)
                2'd0: begin
                    req_be_o    = 4'b0001 << req_addr_lo_i;
                    req_wdata_o = {4{req_wdata_i[7:0]}};
                end
                2'd1: begin
                    req_be_o    = 4'b0011 << {req_addr_lo_i[1], 1'b0};
                    req_wdata_o = {2{req_wdata_i[15:0]}};
                end
                default: begin
                    req_be_o    = 4'b1111;
                    req_wdata_o = req_wdata_i;
                end
            endcase
        end
    end

    assign ld_shifted = ld_rdata_i >> {ld_addr_lo_i, 3'b000};

    always_comb begin
        ld_data_o = ld_rdata_i;
        case (ld_func3_i)
            F3_B:    ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_BU:   ld_data_o = {24'd0, ld_shifted[7:0]};
            F3_H:    ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_HU:   ld_data_o = {16'd0, ld_shifted[15:0]};
            F3_W:    ld_data_o = ld_rdata_i;
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between fetch and load/store; ARB_ROUND_ROBIN_EN selects round-robin grant
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_func3,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic              m_ready,
    input  logic [31:0]       m_rdata,
    output logic              stall
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        lane_q, lane_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [3:0]        m_be_q, m_be_d;
    logic [31:0]       m_wdata_q, m_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]  wait_inc;

    logic              pick_data;
    logic              sel_we;
    logic [2:0]        sel_func3;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic              al_misaligned;
    logic [31:0]       al_ld_data;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e            last_q, last_d;

    // On contention the data side only wins if fetch was granted last.
    assign pick_data = d_req & ~(if_req & (last_q == OWN_D));
`else
    assign pick_data = d_req;
`endif

    assign sel_we    = pick_data ? d_we    : 1'b0;
    assign sel_func3 = pick_data ? d_func3 : F3_W;
    assign sel_addr  = pick_data ? d_addr  : if_addr;
    assign wait_inc  = wait_q + CNT_W'(1);

    mem_lane_align u_align (
        .req_we_i         (sel_we),
        .req_func3_i      (sel_func3),
        .req_addr_lo_i    (sel_addr[1:0]),
        .req_wdata_i      (d_wdata),
        .req_be_o         (al_be),
        .req_wdata_o      (al_wdata),
        .req_misaligned_o (al_misaligned),
        .ld_func3_i       (func3_q),
        .ld_addr_lo_i     (lane_q),
        .ld_rdata_i       (m_rdata),
        .ld_data_o        (al_ld_data)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        func3_d   = func3_q;
        lane_d    = lane_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_be_d    = m_be_q;
        m_wdata_d = m_wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        wait_d    = wait_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    owner_d = pick_data ? OWN_D : OWN_IF;
                    func3_d = sel_func3;
                    lane_d  = sel_addr[1:0];
                    wait_d  = '0;
                    rdata_d = 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = pick_data ? OWN_D : OWN_IF;
`endif
                    if (al_misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d     = 1'b0;
                        m_req_d   = 1'b1;
                        m_we_d    = sel_we;
                        m_addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
                        m_be_d    = al_be;
                        m_wdata_d = al_wdata;
                        state_d   = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // m_ready takes precedence over a timeout landing in the same cycle.
                if (m_ready) begin
                    m_req_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        rdata_d = m_rdata;
                    end else if (m_we_q) begin
                        rdata_d = 32'd0;
                    end else begin
                        rdata_d = al_ld_data;
                    end
                end else if ((MAX_WAIT != 0) && (wait_inc == CNT_W'(MAX_WAIT))) begin
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IF;
            func3_q   <= 3'd0;
            lane_q    <= 2'd0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_be_q    <= 4'd0;
            m_wdata_q <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            wait_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= OWN_IF;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            func3_q   <= func3_d;
            lane_q    <= lane_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_be_q    <= m_be_d;
            m_wdata_q <= m_wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_be    = m_be_q;
    assign m_wdata = m_wdata_q;

    assign if_valid = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign d_valid  = (state_q == ST_RESP) && (owner_q == OWN_D);
    assign if_rdata = (owner_q == OWN_IF) ? rdata_q : 32'd0;
    assign d_rdata  = (owner_q == OWN_D)  ? rdata_q : 32'd0;
    assign if_err   = err_q & (owner_q == OWN_IF);
    assign d_err    = err_q & (owner_q == OWN_D);

    assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench: vector table, contention/reset sequences, randomized model check
module tb_mem_port_arbiter;

    localparam int MAXW = 15;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ready = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [2:0]  d_func3 = '0;
    logic        if_valid, if_err, d_valid, d_err, m_req, m_we, stall;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_be;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
        .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .stall(stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: access size in bytes from the requester and funct3.
    function automatic int acc_size(input bit is_if, input bit we, input int f3);
        if (is_if) return 4;
        if (we) return (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        if (f3 == 0 || f3 == 4) return 1;
        if (f3 == 1 || f3 == 5) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input bit is_if, input bit we, input int f3, input int unsigned a);
        int sz;
        sz = acc_size(is_if, we, f3);
        if (is_if || !we || sz == 4) return 4'hF;
        return 4'((sz == 1 ? 1 : 3) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input int f3, input int unsigned w);
        int sz;
        sz = acc_size(1'b0, 1'b1, f3);
        if (sz == 1) return (w & 255) * 32'h0101_0101;
        if (sz == 2) return (w & 65535) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input int f3, input int unsigned a, input int unsigned word);
        int sz, bits;
        int unsigned v;
        sz = acc_size(1'b0, 1'b0, f3);
        if (sz == 4) return word;
        bits = 8 * sz;
        v = (word >> (8 * (a % 4))) & ((32'd1 << bits) - 1);
        if (f3 < 4 && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    task automatic access(input string name, input bit is_if, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mword,
                          input int lat, input bit exp_mreq, input logic [31:0] exp_maddr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat);
        int busy = 0;
        int cyc = 0;
        bit seen = 0, mseen = 0, stall_bad = 0, vld;
        @(negedge clk);
        m_ready = 1'b0;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_func3 = f3;
        end
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (m_req) begin
                if (!mseen) begin
                    mseen = 1'b1;
                    check({name, " m_addr"}, m_addr, exp_maddr);
                    check({name, " m_be"}, 32'(m_be), 32'(exp_be));
                    check({name, " m_we"}, 32'(m_we), 32'(we & ~is_if));
                    if (we && !is_if) check({name, " m_wdata"}, m_wdata, exp_wdata);
                end
                m_ready = (busy == lat);
                m_rdata = m_ready ? mword : $urandom;
                busy++;
            end else begin
                m_ready = 1'b0;
            end
            vld = is_if ? if_valid : d_valid;
            if (vld) begin
                seen = 1'b1;
                check({name, " rdata"}, is_if ? if_rdata : d_rdata, exp_rdata);
                check({name, " err"}, 32'(is_if ? if_err : d_err), 32'(exp_err));
                check({name, " latency"}, cyc, exp_lat);
                check({name, " stall at valid"}, 32'(stall), 32'd0);
                if_req = 1'b0;
                d_req  = 1'b0;
            end else if (!stall) begin
                stall_bad = 1'b1;
            end
        end
        check({name, " valid seen"}, 32'(seen), 32'd1);
        check({name, " mem access issued"}, 32'(mseen), 32'(exp_mreq));
        if (exp_mreq) check({name, " busy cycles"}, busy, exp_err ? MAXW : lat + 1);
        check({name, " stall while waiting"}, 32'(stall_bad), 32'd0);
        @(negedge clk);
        check({name, " valid one cycle"}, 32'(if_valid | d_valid), 32'd0);
        m_ready = 1'b0;
    endtask

    task automatic run_random(input int idx);
        bit is_if, we, mis, err;
        logic [2:0] f3;
        int unsigned a, w, mw;
        int lat, sz;
        logic [31:0] rd;
        is_if = ($urandom % 4) == 0;
        we    = !is_if && ($urandom % 2);
        f3    = 3'($urandom % 8);
        a     = 32'h400 + ($urandom % 64);
        w     = $urandom;
        mw    = $urandom;
        lat   = ($urandom % 10 == 0) ? 14 + int'($urandom % 3) : int'($urandom % 4);
        sz    = acc_size(is_if, we, int'(f3));
        mis   = (a % sz) != 0;
        err   = mis || (lat >= MAXW);
        if (err) rd = 0;
        else if (is_if) rd = mw;
        else if (we) rd = 0;
        else rd = model_load(int'(f3), a, mw);
        access($sformatf("rnd%0d", idx), is_if, we, f3, a, w, mw, lat, !mis, a & ~32'd3,
               model_be(is_if, we, int'(f3), a), model_wdata(int'(f3), w), rd, err,
               mis ? 1 : (lat >= MAXW - 1) ? MAXW + 1 : lat + 2);
    endtask

    task automatic dual(input string name, input bit exp_data_first);
        bit if_done = 0, d_done = 0, first_seen = 0, first_d = 0;
        logic [31:0] first_addr = 0;
        int cyc = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b010; d_addr = 32'h100;
        while (!(if_done && d_done) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (m_req) begin
                if (!first_seen) begin first_seen = 1'b1; first_addr = m_addr; end
                m_ready = 1'b1;
                m_rdata = m_addr ^ 32'hA5A5_0000;
            end else begin
                m_ready = 1'b0;
            end
            if (d_valid) begin
                if (!if_done) begin
                    first_d = 1'b1;
                    check({name, " stall for fetch"}, 32'(stall), 32'd1);
                end
                d_done = 1'b1;
                check({name, " d_rdata"}, d_rdata, 32'hA5A5_0100);
                d_req = 1'b0;
            end
            if (if_valid) begin
                if (!d_done) check({name, " stall for data"}, 32'(stall), 32'd1);
                if_done = 1'b1;
                check({name, " if_rdata"}, if_rdata, 32'hA5A5_0040);
                if_req = 1'b0;
            end
        end
        check({name, " both served"}, 32'(if_done & d_done), 32'd1);
        check({name, " first m_addr"}, first_addr, exp_data_first ? 32'h100 : 32'h40);
        check({name, " data first"}, 32'(first_d), 32'(exp_data_first));
        m_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        bit          is_if, we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, mword;
        int          lat;
        bit          exp_mreq;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[18];

    task automatic run_vec(input int i);
        access(tbl[i].name, tbl[i].is_if, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
               tbl[i].mword, tbl[i].lat, tbl[i].exp_mreq, tbl[i].exp_maddr, tbl[i].exp_be,
               tbl[i].exp_wdata, tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat);
    endtask

    initial begin
        tbl[0]  = '{"fetch",     1, 0, 3'd2, 32'h10,  0, 32'h0000_0513, 0,  1, 32'h10,  4'hF, 0, 32'h0000_0513, 0, 2};
        tbl[1]  = '{"lw",        0, 0, 3'd2, 32'h100, 0, 32'h1234_5678, 1,  1, 32'h100, 4'hF, 0, 32'h1234_5678, 0, 3};
        tbl[2]  = '{"lb",        0, 0, 3'd0, 32'h203, 0, 32'h80F0_7F01, 0,  1, 32'h200, 4'hF, 0, 32'hFFFF_FF80, 0, 2};
        tbl[3]  = '{"lbu",       0, 0, 3'd4, 32'h203, 0, 32'h80F0_7F01, 0,  1, 32'h200, 4'hF, 0, 32'h0000_0080, 0, 2};
        tbl[4]  = '{"lh",        0, 0, 3'd1, 32'h202, 0, 32'h80F0_7F01, 0,  1, 32'h200, 4'hF, 0, 32'hFFFF_80F0, 0, 2};
        tbl[5]  = '{"lhu",       0, 0, 3'd5, 32'h202, 0, 32'h80F0_7F01, 0,  1, 32'h200, 4'hF, 0, 32'h0000_80F0, 0, 2};
        tbl[6]  = '{"lb0",       0, 0, 3'd0, 32'h200, 0, 32'h80F0_7F01, 2,  1, 32'h200, 4'hF, 0, 32'h0000_0001, 0, 4};
        tbl[7]  = '{"sb",        0, 1, 3'd0, 32'h305, 32'hAB, 32'h5555, 0, 1, 32'h304, 4'b0010, 32'hABAB_ABAB, 0, 0, 2};
        tbl[8]  = '{"sh_mis",    0, 1, 3'd1, 32'h301, 32'h1234, 0, 0,   0, 32'h0,   4'h0, 0, 0, 1, 1};
        tbl[9]  = '{"sh",        0, 1, 3'd1, 32'h302, 32'hCAFE_1234, 0, 1, 1, 32'h300, 4'b1100, 32'h1234_1234, 0, 0, 3};
        tbl[10] = '{"sw",        0, 1, 3'd2, 32'h300, 32'hDEAD_BEEF, 0, 0, 1, 32'h300, 4'hF, 32'hDEAD_BEEF, 0, 0, 2};
        tbl[11] = '{"lw_mis",    0, 0, 3'd2, 32'h102, 0, 0, 0,        0, 32'h0,   4'h0, 0, 0, 1, 1};
        tbl[12] = '{"if_mis",    1, 0, 3'd2, 32'h12,  0, 0, 0,        0, 32'h0,   4'h0, 0, 0, 1, 1};
        tbl[13] = '{"lw_edge",   0, 0, 3'd2, 32'h104, 0, 32'h0BAD_F00D, 14, 1, 32'h104, 4'hF, 0, 32'h0BAD_F00D, 0, 16};
        tbl[14] = '{"lw_tmo",    0, 0, 3'd2, 32'h104, 0, 32'h0BAD_F00D, 99, 1, 32'h104, 4'hF, 0, 32'h0, 1, 16};
        tbl[15] = '{"sw_tmo",    0, 1, 3'd3, 32'h308, 32'h1122_3344, 0, 99, 1, 32'h308, 4'hF, 32'h1122_3344, 0, 1, 16};
        tbl[16] = '{"lhu_mis",   0, 0, 3'd5, 32'h203, 0, 0, 0,        0, 32'h0,   4'h0, 0, 0, 1, 1};
        tbl[17] = '{"sb3",       0, 1, 3'd0, 32'h307, 32'h1234_56C3, 0, 0, 1, 32'h304, 4'b1000, 32'hC3C3_C3C3, 0, 0, 2};

        #1;
        check("reset m_req", 32'(m_req), 32'd0);
        check("reset valids", 32'(if_valid | d_valid), 32'd0);
        check("reset errs", 32'(if_err | d_err), 32'd0);
        check("reset m_addr", m_addr, 32'd0);
        check("reset m_be", 32'(m_be), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) run_vec(i);

        run_vec(0);
        dual("dual1", 1'b1);
        run_vec(1);
        dual("dual2", !RR);

        // Asynchronous reset while an access is outstanding.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b010; d_addr = 32'h100; m_ready = 1'b0;
        @(negedge clk);
        check("pre-reset m_req", 32'(m_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async reset m_req", 32'(m_req), 32'd0);
        check("async reset valids", 32'(if_valid | d_valid), 32'd0);
        check("async reset errs", 32'(if_err | d_err), 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        access("after reset", 0, 0, 3'd2, 32'h100, 0, 32'h1234_5678, 1, 1, 32'h100, 4'hF, 0,
               32'h1234_5678, 0, 3);

        for (int i = 0; i < 120; i++) run_random(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
